// File: rtl/multicycle_pkg.sv
// multicycle_pkg: states, opcodes and control encodings for the RV32I multi-cycle controller.
package multicycle_pkg;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
`ifdef RISCV_MULTICYCLE_ILLEGAL_TRAP_EN
      , S_ILLEGAL
`endif
   } state_t;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: combinational map from aluOp/funct3/opcode[5]/funct7b5 to ALU control.
module alu_decoder
   import multicycle_pkg::*;
(
   input  logic [1:0] i_aluOp,
   input  logic [2:0] i_funct3,
   input  logic       i_op5,
   input  logic       i_funct7b5,
   output logic [2:0] o_aluControl
);
   always_comb begin
      o_aluControl = ALU_ADD;
      if (i_aluOp == ALUOP_SUB) o_aluControl = ALU_SUB;
      else if (i_aluOp == ALUOP_FUNC)
         case (i_funct3)
            3'b000:  o_aluControl = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  o_aluControl = ALU_SLT;
            3'b110:  o_aluControl = ALU_OR;
            3'b111:  o_aluControl = ALU_AND;
            default: o_aluControl = ALU_ADD;
         endcase
   end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle control FSM with retired-instruction counter;
// RISCV_MULTICYCLE_ILLEGAL_TRAP_EN adds a sticky ILLEGAL trap state.
module multicycle_controller
   import multicycle_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_srst,
   input  logic [6:0]  i_opcode,
   input  logic [2:0]  i_funct3,
   input  logic        i_funct7b5,
   input  logic        i_zero,
   output logic        o_pcWrite,
   output logic        o_adrSrc,
   output logic        o_memWrite,
   output logic        o_irWrite,
   output logic        o_regWrite,
   output logic [1:0]  o_resultSrc,
   output logic [1:0]  o_aluSrcA,
   output logic [1:0]  o_aluSrcB,
   output logic [1:0]  o_immSrc,
   output logic [2:0]  o_aluControl,
   output logic [31:0] o_instret,
   output logic        o_illegal
);
   state_t r_state, w_next;
   logic w_pcUpdate, w_branch, w_adrSrc, w_memWrite, w_irWrite, w_regWrite, w_retire, w_quiet;
   logic [1:0] w_resultSrc, w_aluSrcA, w_aluSrcB, w_aluOp, w_immSrc;
   logic [2:0] w_aluControl;
   logic [31:0] r_instret;

   always_ff @(posedge i_clk) r_state <= i_srst ? S_FETCH : w_next;

   always_comb begin
      w_next      = r_state;
      w_pcUpdate  = 1'b0;
      w_branch    = 1'b0;
      w_adrSrc    = 1'b0;
      w_memWrite  = 1'b0;
      w_irWrite   = 1'b0;
      w_regWrite  = 1'b0;
      w_resultSrc = RES_ALUOUT;
      w_aluSrcA   = SRCA_PC;
      w_aluSrcB   = SRCB_RS2;
      w_aluOp     = ALUOP_ADD;
      case (r_state)
         S_FETCH: begin
            w_irWrite   = 1'b1;
            w_pcUpdate  = 1'b1;
            w_aluSrcB   = SRCB_FOUR;
            w_resultSrc = RES_ALURES;
            w_next      = S_DECODE;
         end
         S_DECODE: begin
            w_aluSrcA = SRCA_OLDPC;
            w_aluSrcB = SRCB_IMM;
            case (i_opcode)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_RTYPE:          w_next = S_EXECUTER;
               OP_ITYPE:          w_next = S_EXECUTEI;
               OP_BRANCH:         w_next = S_BEQ;
               OP_JAL:            w_next = S_JAL;
`ifdef RISCV_MULTICYCLE_ILLEGAL_TRAP_EN
               default:           w_next = S_ILLEGAL;
`else
               default:           w_next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            w_aluSrcA = SRCA_RS1;
            w_aluSrcB = SRCB_IMM;
`ifdef RISCV_MULTICYCLE_ILLEGAL_TRAP_EN
            w_next = (i_opcode == OP_LOAD) ? S_MEMREAD : (i_opcode == OP_STORE) ? S_MEMWRITE : S_ILLEGAL;
`else
            w_next = (i_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
`endif
         end
         S_MEMREAD: begin
            w_adrSrc = 1'b1;
            w_next   = S_MEMWB;
         end
         S_MEMWB: begin
            w_resultSrc = RES_DATA;
            w_regWrite  = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEMWRITE: begin
            w_adrSrc   = 1'b1;
            w_memWrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_EXECUTER: begin
            w_aluSrcA = SRCA_RS1;
            w_aluOp   = ALUOP_FUNC;
            w_next    = S_ALUWB;
         end
         S_EXECUTEI: begin
            w_aluSrcA = SRCA_RS1;
            w_aluSrcB = SRCB_IMM;
            w_aluOp   = ALUOP_FUNC;
            w_next    = S_ALUWB;
         end
         S_ALUWB: begin
            w_regWrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_BEQ: begin
            w_aluSrcA = SRCA_RS1;
            w_aluOp   = ALUOP_SUB;
            w_branch  = 1'b1;
            w_next    = S_FETCH;
         end
         S_JAL: begin
            w_aluSrcA  = SRCA_OLDPC;
            w_aluSrcB  = SRCB_FOUR;
            w_pcUpdate = 1'b1;
            w_next     = S_ALUWB;
         end
         default: w_next = r_state;
      endcase
   end

   alu_decoder u_alu_decoder (
      .i_aluOp      (w_aluOp),
      .i_funct3     (i_funct3),
      .i_op5        (i_opcode[5]),
      .i_funct7b5   (i_funct7b5),
      .o_aluControl (w_aluControl)
   );

   always_comb w_immSrc = (i_opcode == OP_STORE) ? IMM_S : (i_opcode == OP_BRANCH) ? IMM_B :
                          (i_opcode == OP_JAL) ? IMM_J : IMM_I;

   assign w_retire = r_state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ};

   always_ff @(posedge i_clk)
      if (i_srst) r_instret <= '0;
      else if (w_retire) r_instret <= r_instret + 32'd1;

`ifdef RISCV_MULTICYCLE_ILLEGAL_TRAP_EN
   logic r_illegal;
   always_ff @(posedge i_clk) r_illegal <= i_srst ? 1'b0 : (r_illegal | (w_next == S_ILLEGAL));
   assign w_quiet   = i_srst | (r_state == S_ILLEGAL);
   assign o_illegal = r_illegal & ~i_srst;
`else
   assign w_quiet   = i_srst;
   assign o_illegal = 1'b0;
`endif

   // Reset (and the trap state) silences every output, including the immediate decode.
   assign o_pcWrite    = ~w_quiet & (w_pcUpdate | (w_branch & i_zero));
   assign o_adrSrc     = ~w_quiet & w_adrSrc;
   assign o_memWrite   = ~w_quiet & w_memWrite;
   assign o_irWrite    = ~w_quiet & w_irWrite;
   assign o_regWrite   = ~w_quiet & w_regWrite;
   assign o_resultSrc  = w_quiet ? 2'b00 : w_resultSrc;
   assign o_aluSrcA    = w_quiet ? 2'b00 : w_aluSrcA;
   assign o_aluSrcB    = w_quiet ? 2'b00 : w_aluSrcB;
   assign o_immSrc     = w_quiet ? 2'b00 : w_immSrc;
   assign o_aluControl = w_quiet ? 3'b000 : w_aluControl;
   assign o_instret    = i_srst ? 32'd0 : r_instret;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle checks of the multi-cycle controller outputs.
module tb_multicycle_controller;
   logic clk = 1'b0, srst = 1'b1, f7 = 1'b0, zero = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
   logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
   logic [2:0] aluControl;
   logic [31:0] instret, exp_instret = 32'd0;
   logic [15:0] sig;
   int n_checks = 0, n_fail = 0;

   multicycle_controller dut (
      .i_clk(clk), .i_srst(srst), .i_opcode(opcode), .i_funct3(funct3), .i_funct7b5(f7), .i_zero(zero),
      .o_pcWrite(pcWrite), .o_adrSrc(adrSrc), .o_memWrite(memWrite), .o_irWrite(irWrite),
      .o_regWrite(regWrite), .o_resultSrc(resultSrc), .o_aluSrcA(aluSrcA), .o_aluSrcB(aluSrcB),
      .o_immSrc(immSrc), .o_aluControl(aluControl), .o_instret(instret), .o_illegal(illegal)
   );

   always #5 clk = ~clk;

   // {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc, aluSrcA, aluSrcB, immSrc, aluControl}
   assign sig = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc, aluSrcA, aluSrcB, immSrc, aluControl};

   task automatic load(input logic [31:0] instr);
      opcode = instr[6:0];
      funct3 = instr[14:12];
      f7     = instr[30];
   endtask

   task automatic test_reset;
      srst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (sig !== 16'd0 || instret !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_hold: sig=%b instret=%h required 0/0", sig, instret);
      end
      srst = 1'b0;
      #1;
      n_checks++;
      if (irWrite !== 1'b1 || pcWrite !== 1'b1 || instret !== 32'd0 || illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: irWrite=%b pcWrite=%b instret=%h illegal=%b required 1/1/0/0",
                  irWrite, pcWrite, instret, illegal);
      end
      n_checks++;
      if (sig !== 16'b1_0_0_1_0_10_00_10_00_000) begin
         n_fail++;
         $display("FAIL reset_fetch: sig=%b required %b", sig, 16'b1_0_0_1_0_10_00_10_00_000);
      end
   endtask

   task automatic test_lw;
      logic [15:0] e [5] = '{16'b1_0_0_1_0_10_00_10_00_000, 16'b0_0_0_0_0_00_01_01_00_000,
                             16'b0_0_0_0_0_00_10_01_00_000, 16'b0_1_0_0_0_00_00_00_00_000,
                             16'b0_0_0_0_1_01_00_00_00_000};
      load(32'hFFC4A303);
      #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++;
         if (sig !== e[i]) begin
            n_fail++;
            $display("FAIL lw_cycle%0d: sig=%b required %b", i, sig, e[i]);
         end
      end
      @(negedge clk);
      exp_instret++;
      n_checks++;
      if (instret !== exp_instret || irWrite !== 1'b1) begin
         n_fail++;
         $display("FAIL lw_retire: instret=%h irWrite=%b required %h/1", instret, irWrite, exp_instret);
      end
   endtask

   task automatic test_sw;
      logic [15:0] e [4] = '{16'b1_0_0_1_0_10_00_10_01_000, 16'b0_0_0_0_0_00_01_01_01_000,
                             16'b0_0_0_0_0_00_10_01_01_000, 16'b0_1_1_0_0_00_00_00_01_000};
      load(32'h0064A423);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++;
         if (sig !== e[i]) begin
            n_fail++;
            $display("FAIL sw_cycle%0d: sig=%b required %b", i, sig, e[i]);
         end
      end
      @(negedge clk);
      exp_instret++;
      n_checks++;
      if (instret !== exp_instret || irWrite !== 1'b1 || memWrite !== 1'b0) begin
         n_fail++;
         $display("FAIL sw_retire: instret=%h irWrite=%b memWrite=%b required %h/1/0",
                  instret, irWrite, memWrite, exp_instret);
      end
   endtask

   task automatic test_alu_ops;
      logic [31:0] instr [5] = '{32'h40628233, 32'h0062E233, 32'hFFF10093, 32'h00512093, 32'h0FF17093};
      logic [2:0]  ctl   [5] = '{3'b001, 3'b011, 3'b000, 3'b101, 3'b010};
      logic [1:0]  srcb  [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
      logic [15:0] e [4];
      for (int j = 0; j < 5; j++) begin
         e = '{16'b1_0_0_1_0_10_00_10_00_000, 16'b0_0_0_0_0_00_01_01_00_000,
               {9'b0_0_0_0_0_00_10, srcb[j], 2'b00, ctl[j]}, 16'b0_0_0_0_1_00_00_00_00_000};
         load(instr[j]);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (sig !== e[i]) begin
               n_fail++;
               $display("FAIL alu_%h_cycle%0d: sig=%b required %b", instr[j], i, sig, e[i]);
            end
         end
         @(negedge clk);
         exp_instret++;
         n_checks++;
         if (instret !== exp_instret) begin
            n_fail++;
            $display("FAIL alu_%h_retire: instret=%h required %h", instr[j], instret, exp_instret);
         end
      end
   endtask

   task automatic test_beq;
      for (int z = 1; z >= 0; z--) begin
         logic [15:0] e [3];
         e = '{16'b1_0_0_1_0_10_00_10_10_000, 16'b0_0_0_0_0_00_01_01_10_000,
               {z[0], 15'b0_0_0_0_00_10_00_10_001}};
         zero = z[0];
         load(32'h00208463);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (sig !== e[i]) begin
               n_fail++;
               $display("FAIL beq_zero%0d_cycle%0d: sig=%b required %b", z, i, sig, e[i]);
            end
         end
         @(negedge clk);
         exp_instret++;
         n_checks++;
         if (instret !== exp_instret || irWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL beq_zero%0d_retire: instret=%h irWrite=%b required %h/1", z, instret, irWrite, exp_instret);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_jal;
      logic [15:0] e [4] = '{16'b1_0_0_1_0_10_00_10_11_000, 16'b0_0_0_0_0_00_01_01_11_000,
                             16'b1_0_0_0_0_00_01_10_11_000, 16'b0_0_0_0_1_00_00_00_11_000};
      load(32'h010000EF);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++;
         if (sig !== e[i]) begin
            n_fail++;
            $display("FAIL jal_cycle%0d: sig=%b required %b", i, sig, e[i]);
         end
      end
      @(negedge clk);
      exp_instret++;
      n_checks++;
      if (instret !== exp_instret) begin
         n_fail++;
         $display("FAIL jal_retire: instret=%h required %h", instret, exp_instret);
      end
   endtask

   task automatic test_illegal;
      load(32'h0000007F);
      @(negedge clk);
      n_checks++;
      if (sig !== 16'b0_0_0_0_0_00_01_01_00_000) begin
         n_fail++;
         $display("FAIL illegal_decode: sig=%b required %b", sig, 16'b0_0_0_0_0_00_01_01_00_000);
      end
`ifdef RISCV_MULTICYCLE_ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (sig !== 16'd0 || illegal !== 1'b1 || instret !== exp_instret) begin
            n_fail++;
            $display("FAIL illegal_stuck%0d: sig=%b illegal=%b instret=%h required 0/1/%h",
                     i, sig, illegal, instret, exp_instret);
         end
      end
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      #1;
      exp_instret = 32'd0;
      n_checks++;
      if (illegal !== 1'b0 || instret !== 32'd0 || sig !== 16'b1_0_0_1_0_10_00_10_00_000) begin
         n_fail++;
         $display("FAIL illegal_cleared: illegal=%b instret=%h sig=%b required 0/0/fetch", illegal, instret, sig);
      end
`else
      @(negedge clk);
      n_checks++;
      if (sig !== 16'b1_0_0_1_0_10_00_10_00_000 || instret !== exp_instret || illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_nop: sig=%b instret=%h illegal=%b required fetch/%h/0", sig, instret, illegal, exp_instret);
      end
`endif
   endtask

   task automatic test_wrap;
      load(32'h00208463);
      zero = 1'b0;
      #1;
      force dut.r_instret = 32'hFFFFFFFF;
      @(negedge clk);
      release dut.r_instret;
      #1;
      n_checks++;
      if (instret !== 32'hFFFFFFFF) begin
         n_fail++;
         $display("FAIL wrap_preload: instret=%h required ffffffff", instret);
      end
      @(negedge clk);
      @(negedge clk);
      exp_instret = 32'd0;
      n_checks++;
      if (instret !== exp_instret) begin
         n_fail++;
         $display("FAIL wrap: instret=%h required %h", instret, exp_instret);
      end
   endtask

   task automatic test_mid_reset;
      load(32'hFFC4A303);
      for (int i = 0; i < 4; i++) @(negedge clk);
      srst = 1'b1;
      #1;
      n_checks++;
      if (sig !== 16'd0 || regWrite !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_quiet: sig=%b regWrite=%b required 0/0", sig, regWrite);
      end
      @(negedge clk);
      srst = 1'b0;
      #1;
      exp_instret = 32'd0;
      n_checks++;
      if (sig !== 16'b1_0_0_1_0_10_00_10_00_000 || instret !== exp_instret) begin
         n_fail++;
         $display("FAIL midreset_fetch: sig=%b instret=%h required fetch/%h", sig, instret, exp_instret);
      end
   endtask

   initial begin
      test_reset;
      test_lw;
      test_sw;
      test_alu_ops;
      test_beq;
      test_jal;
      test_illegal;
      test_wrap;
      test_mid_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM plus ALU and immediate decoders that sequence a multi-cycle RV32I datapath: one shared memory, a single ALU, and an instruction register, reusing the PC, register file, extend, ALU and memory blocks. Each instruction takes 3 to 5 cycles. All datapath enables and mux selects come from this block. It also keeps a retired-instruction counter.

## Interface
- No parameters.
- i_clk  input  1  clock
- i_srst  input  1  synchronous, active-high reset
- i_opcode  input  7  instruction[6:0], from the instruction register (stable after FETCH)
- i_funct3  input  3  instruction[14:12]
- i_funct7b5  input  1  instruction[30]
- i_zero  input  1  ALU result == 0
- o_pcWrite  output  1  PC register enable
- o_adrSrc  output  1  memory address: 0 = PC, 1 = ALU result register
- o_memWrite  output  1  data memory write enable
- o_irWrite  output  1  instruction and old-PC register enable
- o_regWrite  output  1  register file write enable
- o_resultSrc  output  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result
- o_aluSrcA  output  2  ALU A: 00 = PC, 01 = oldPC, 10 = rs1
- o_aluSrcB  output  2  ALU B: 00 = rs2, 01 = immediate, 10 = constant 4
- o_immSrc  output  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J
- o_aluControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- o_instret  output  32  retired-instruction count
- o_illegal  output  1  sticky illegal-opcode flag (only with the macro below)

## Operation
- Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, plus ILLEGAL when the macro is defined.
- Any output not listed for a state is 0.
- FETCH: irWrite=1, pcUpdate=1, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10. Goes to DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (computes the branch target).
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → see Configuration
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Goes to MEMREAD if opcode is 0000011, else MEMWRITE.
- MEMREAD: adrSrc=1, resultSrc=00. Goes to MEMWB.
- MEMWB: resultSrc=01, regWrite=1. Goes to FETCH.
- MEMWRITE: adrSrc=1, memWrite=1. Goes to FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10. Goes to ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10. Goes to ALUWB.
- ALUWB: resultSrc=00, regWrite=1. Goes to FETCH.
- BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, branch=1. Goes to FETCH.
- JAL: aluSrcA=01, aluSrcB=10, aluOp=00, pcUpdate=1. Goes to ALUWB (writes the link register).
- o_pcWrite = pcUpdate | (branch & i_zero). This is the only Mealy term.
- ALU decode:
  - aluOp 00 → add; aluOp 01 → sub.
  - aluOp 10, funct3 000 → sub if (i_opcode[5] & i_funct7b5), else add.
  - aluOp 10, funct3 010 → slt; 110 → or; 111 → and; any other funct3 → add.
- o_immSrc is decoded combinationally from i_opcode:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - everything else → 00
- o_instret increments by 1 (mod 2^32) on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - state = FETCH
  - o_instret = 0
  - o_illegal = 0
- Every output is forced to 0 while i_srst is high. In the first cycle after reset is released, the FETCH outputs are present.
- Reset mid-instruction: the partial instruction is abandoned and not counted. No write enable is asserted in the reset cycle.
- Cycles per instruction: beq 3; sw, R-type, I-type and jal 4; lw 5.
- o_instret is registered: the new value is visible in the FETCH cycle that follows the retiring state.
- If the branch is not taken (i_zero = 0 in BEQ), o_pcWrite stays 0 and the PC keeps the PC+4 value written during FETCH.

## Configuration
- Macro: RISCV_MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE, or in MEMADR, moves to ILLEGAL.
  - ILLEGAL holds all outputs at 0 and never exits except on reset.
  - o_illegal is set to 1 on entry to ILLEGAL and stays set until reset.
  - o_instret does not increment.
- Not defined:
  - An unrecognised opcode returns to FETCH from DECODE. It behaves as a NOP and is not counted.
  - o_illegal is tied to 0.

## Structure
- Package multicycle_pkg holds:
  - the state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL)
  - the aluOp, aluControl, immSrc, resultSrc, aluSrcA and aluSrcB encodings
- Sub-module alu_decoder maps (aluOp, funct3, opcode[5], funct7b5) to aluControl. It is purely combinational.
- The FSM, the output decode, the immediate decode and the counter stay in the top module.

## Test plan
- Reset: hold i_srst for 2 cycles, then release. In the first cycle after release: state = FETCH, o_irWrite = 1, o_pcWrite = 1, o_instret = 0.
- lw x6, -4(x9), encoding 0xFFC4A303:
  - states FETCH → DECODE → MEMADR → MEMREAD → MEMWB
  - o_adrSrc = 1 in MEMREAD; o_regWrite = 1 with o_resultSrc = 01 in MEMWB
  - o_instret goes 0 → 1
- sw x6, 8(x9), encoding 0x0064A423: o_memWrite = 1 only in cycle 4 and o_immSrc = 01 in that cycle; 4 cycles total.
- sub x4, x5, x6, encoding 0x40628233:
  - o_aluControl = 001 in EXECUTER
  - o_regWrite = 1 in ALUWB
  - or x4, x5, x6 (0x0062E233) gives 011 in EXECUTER
- beq with i_zero = 1: o_pcWrite = 1 in BEQ. Same instruction with i_zero = 0: o_pcWrite = 0. Both cases take 3 cycles and increment o_instret by 1.
- Opcode 0x7F:
  - with the macro: stuck in ILLEGAL, o_illegal = 1, o_instret unchanged for 10 cycles, cleared by reset
  - without the macro: returns to FETCH after DECODE, o_instret unchanged
- Counter wrap (preload via force): o_instret = 0xFFFFFFFF goes to 0 after one retire.
